pc_target_table: RTL and testbench

PC_TARGET_TABLE -- requirements
Module: pc_target_table

---
 rtl/pc_pkg.sv | 38 +++
 rtl/pc_target_resolve.sv | 31 +++
 rtl/pc_target_table.sv | 135 +++++++++++++
 tb/tb_pc_target_table.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and the power-on branch-target table for pc_target_table.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. Exports state_e, DEF_DEPTH, DEF_VALID_MASK, def_value(), def_valid().
package pc_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_DEPTH = 16;

    // Entries 0..10 hold real defaults; 11..15 start out unprogrammed.
    localparam logic [15:0] DEF_VALID_MASK = 16'h07FF;

    function automatic logic [31:0] def_value(input int unsigned idx);
        case (idx)
            0:       return 32'd0;
            1:       return 32'd11;
            2:       return 32'd80;
            3:       return 32'd121;
            4:       return 32'd55;
            5:       return 32'd109;
            6:       return 32'd101;
            7:       return 32'd118;
            8:       return 32'd1;
            9:       return 32'd20;
            10:      return 32'd95;
            default: return 32'd0;
        endcase
    endfunction

    // Indices past the default table (larger A) come up invalid.
    function automatic logic def_valid(input int unsigned idx);
        return (idx < DEF_DEPTH) ? DEF_VALID_MASK[idx[3:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/pc_target_resolve.sv
// Turns a captured table entry into the final branch target (absolute or PC-relative).
// Latency: combinational. Backpressure: none.
// Ports: req_vld_i/ent_vld_i/ent_rel_i/ent_val_i/pc_i in; target_o, miss_o out (both 0 unless req_vld_i).
module pc_target_resolve #(
    parameter int D = 10
) (
    input  logic         req_vld_i,
    input  logic         ent_vld_i,
    input  logic         ent_rel_i,
    input  logic [D-1:0] ent_val_i,
    input  logic [D-1:0] pc_i,
    output logic [D-1:0] target_o,
    output logic         miss_o
);

    always_comb begin
        target_o = '0;
        miss_o   = 1'b0;
        if (req_vld_i) begin
            if (!ent_vld_i) begin
                miss_o = 1'b1;
            end else if (ent_rel_i) begin
                // D-bit add wraps modulo 2**D, so a negative offset works as-is.
                target_o = pc_i + ent_val_i;
            end else begin
                target_o = ent_val_i;
            end
        end
    end

endmodule

// File: rtl/pc_target_table.sv
// Programmable branch-target table: INIT walk loads defaults, RUN serves lookups and writes.
// Latency: 1 cycle lookup->lk_valid, one lookup per cycle; INIT lasts 2**A cycles.
// Backpressure: none once lk_ready; lookups/writes outside RUN are dropped.
module pc_target_table
    import pc_pkg::*;
#(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lk_req,
    input  logic [A-1:0] lk_addr,
    input  logic [D-1:0] lk_pc,
    output logic         lk_ready,
    output logic         lk_valid,
    output logic [D-1:0] lk_target,
    output logic         lk_miss,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         wr_rel,
    input  logic         reload
);

    localparam int DEPTH = 2**A;

    state_e         state_q;
    logic [A-1:0]   idx_q;
    logic [D-1:0]   val_q [DEPTH];
    logic [DEPTH-1:0] rel_q;
    logic [DEPTH-1:0] vld_q;

    logic           run;
    logic           lk_acc;
    logic           wr_take;

    logic [D-1:0]   ent_val_d, ent_val_q;
    logic           ent_rel_d, ent_rel_q;
    logic           ent_vld_d, ent_vld_q;
    logic [D-1:0]   pc_q;
    logic           acc_q;

    assign run      = (state_q == ST_RUN);
    assign lk_ready = run;
    assign lk_acc   = lk_req && run;
    // A reload in the same cycle wins over a write.
    assign wr_take  = wr_en && run && !reload;

    // FSM and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
            end
            rel_q   <= '0;
            vld_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    val_q[idx_q] <= D'(def_value(32'(idx_q)));
                    rel_q[idx_q] <= 1'b0;
                    vld_q[idx_q] <= def_valid(32'(idx_q));
                    if (idx_q == A'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                    end else begin
                        idx_q   <= idx_q + A'(1);
                    end
                end
                ST_RUN: begin
                    if (reload) begin
                        state_q <= ST_INIT;
                        idx_q   <= '0;
                    end else if (wr_take) begin
                        val_q[wr_addr] <= wr_data;
                        rel_q[wr_addr] <= wr_rel;
                        vld_q[wr_addr] <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Entry seen by a lookup; a same-cycle write to that address is forwarded.
    always_comb begin
        ent_val_d = val_q[lk_addr];
        ent_rel_d = rel_q[lk_addr];
        ent_vld_d = vld_q[lk_addr];
        if (wr_take && (wr_addr == lk_addr)) begin
            ent_val_d = wr_data;
            ent_rel_d = wr_rel;
            ent_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= 1'b0;
            ent_val_q <= '0;
            ent_rel_q <= 1'b0;
            ent_vld_q <= 1'b0;
            pc_q      <= '0;
        end else begin
            acc_q <= lk_acc;
            if (lk_acc) begin
                ent_val_q <= ent_val_d;
                ent_rel_q <= ent_rel_d;
                ent_vld_q <= ent_vld_d;
                pc_q      <= lk_pc;
            end
        end
    end

    assign lk_valid = acc_q;

    pc_target_resolve #(
        .D (D)
    ) u_resolve (
        .req_vld_i (acc_q),
        .ent_vld_i (ent_vld_q),
        .ent_rel_i (ent_rel_q),
        .ent_val_i (ent_val_q),
        .pc_i      (pc_q),
        .target_o  (lk_target),
        .miss_o    (lk_miss)
    );

endmodule

// File: tb/tb_pc_target_table.sv
// Self-checking bench for pc_target_table: directed vectors, behavioural table model,
// per-cycle compare on the falling edge plus literal expectations.
module tb_pc_target_table;

    logic       clk;
    logic       rst_n;
    logic       lk_req;
    logic [3:0] lk_addr;
    logic [9:0] lk_pc;
    logic       lk_ready;
    logic       lk_valid;
    logic [9:0] lk_target;
    logic       lk_miss;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [9:0] wr_data;
    logic       wr_rel;
    logic       reload;

    int checks   = 0;
    int failures = 0;

    pc_target_table #(.D(10), .A(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_req    (lk_req),
        .lk_addr   (lk_addr),
        .lk_pc     (lk_pc),
        .lk_ready  (lk_ready),
        .lk_valid  (lk_valid),
        .lk_target (lk_target),
        .lk_miss   (lk_miss),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rel    (wr_rel),
        .reload    (reload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         def_tab [11] = '{0, 11, 80, 121, 55, 109, 101, 118, 1, 20, 95};
    logic [9:0] m_val [16];
    logic       m_rel [16];
    logic       m_vld [16];
    int         m_busy;        // cycles of INIT remaining; 0 means ready
    logic       e_valid;
    logic [9:0] e_target;
    logic       e_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 16;
        e_valid  = 1'b0;
        e_target = '0;
        e_miss   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_val[i] = '0;
            m_rel[i] = 1'b0;
            m_vld[i] = 1'b0;
        end
    endtask

    task automatic model_load_defaults();
        for (int i = 0; i < 16; i++) begin
            m_val[i] = (i < 11) ? 10'(def_tab[i]) : 10'd0;
            m_rel[i] = 1'b0;
            m_vld[i] = (i < 11);
        end
    endtask

    // Called at each rising edge while out of reset, using the inputs held over that edge.
    task automatic model_edge();
        logic       ready;
        logic [9:0] v;
        logic       r;
        logic       ok;
        ready = (m_busy == 0);
        if (lk_req && ready) begin
            v  = m_val[lk_addr];
            r  = m_rel[lk_addr];
            ok = m_vld[lk_addr];
            if (wr_en && !reload && wr_addr == lk_addr) begin
                v  = wr_data;
                r  = wr_rel;
                ok = 1'b1;
            end
            e_valid  = 1'b1;
            e_miss   = !ok;
            e_target = !ok ? 10'd0 : (r ? 10'((32'(lk_pc) + 32'(v)) % 1024) : v);
        end else begin
            e_valid  = 1'b0;
            e_target = '0;
            e_miss   = 1'b0;
        end
        if (ready) begin
            if (reload) begin
                m_busy = 16;
            end else if (wr_en) begin
                m_val[wr_addr] = wr_data;
                m_rel[wr_addr] = wr_rel;
                m_vld[wr_addr] = 1'b1;
            end
        end else begin
            m_busy--;
            if (m_busy == 0) model_load_defaults();
        end
    endtask

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_ready",  32'(lk_ready),  32'(m_busy == 0));
        chk("cmp_valid",  32'(lk_valid),  32'(e_valid));
        chk("cmp_target", 32'(lk_target), 32'(e_target));
        chk("cmp_miss",   32'(lk_miss),   32'(e_miss));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        lk_req  = 1'b0;
        lk_addr = '0;
        lk_pc   = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_rel  = 1'b0;
        reload  = 1'b0;
    endtask

    task automatic do_cycle(input logic req, input logic [3:0] addr, input logic [9:0] pc,
                            input logic we, input logic [3:0] waddr, input logic [9:0] wdata,
                            input logic wrel, input logic rl);
        lk_req  = req;
        lk_addr = addr;
        lk_pc   = pc;
        wr_en   = we;
        wr_addr = waddr;
        wr_data = wdata;
        wr_rel  = wrel;
        reload  = rl;
        tick();
        clear_inputs();
    endtask

    task automatic count_init(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!lk_ready && n < 100);
    endtask

    task automatic lookup_lit(input string name, input logic [3:0] addr, input logic [9:0] pc,
                              input logic [9:0] exp_tgt, input logic exp_miss);
        do_cycle(1'b1, addr, pc, 1'b0, 4'd0, 10'd0, 1'b0, 1'b0);
        chk({name, "_valid"},  32'(lk_valid),  32'd1);
        chk({name, "_target"}, 32'(lk_target), 32'(exp_tgt));
        chk({name, "_miss"},   32'(lk_miss),   32'(exp_miss));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        chk("rst_ready", 32'(lk_ready), 32'd0);
        chk("rst_valid", 32'(lk_valid), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Power-up walk, then first lookup.
        count_init(n);
        chk("init_len_poweron", 32'(n), 32'd16);
        lookup_lit("lk2", 4'd2, 10'd0, 10'd80, 1'b0);
        tick();
        chk("lk2_pulse_gone", 32'(lk_valid), 32'd0);

        // Relative entries, negative and positive offsets.
        do_cycle(1'b0, 4'd0, 10'd0, 1'b1, 4'd12, 10'h3FB, 1'b1, 1'b0);
        lookup_lit("rel12", 4'd12, 10'd4, 10'h3FF, 1'b0);
        do_cycle(1'b0, 4'd0, 10'd0, 1'b1, 4'd13, 10'd20, 1'b1, 1'b0);
        lookup_lit("rel13", 4'd13, 10'd4, 10'd24, 1'b0);

        // Unprogrammed entry.
        lookup_lit("miss15", 4'd15, 10'd77, 10'd0, 1'b1);

        // Write-first on same address.
        do_cycle(1'b1, 4'd3, 10'd9, 1'b1, 4'd3, 10'd200, 1'b0, 1'b0);
        chk("wf3_target", 32'(lk_target), 32'd200);
        chk("wf3_valid",  32'(lk_valid),  32'd1);

        // Overwrite addr 1, then reload with a same-cycle lookup (old data) and write (dropped).
        do_cycle(1'b0, 4'd0, 10'd0, 1'b1, 4'd1, 10'd500, 1'b0, 1'b0);
        do_cycle(1'b1, 4'd1, 10'd0, 1'b1, 4'd4, 10'd9, 1'b0, 1'b1);
        chk("rl_lk_target", 32'(lk_target), 32'd500);
        chk("rl_ready_low", 32'(lk_ready),  32'd0);
        // During INIT: lookups, writes and a second reload must all be ignored.
        n = 0;
        while (!lk_ready && n < 100) begin
            lk_req  = 1'b1;
            lk_addr = 4'(n);
            wr_en   = 1'b1;
            wr_addr = 4'd5;
            wr_data = 10'd7;
            reload  = (n == 3);
            tick();
            n++;
        end
        clear_inputs();
        chk("init_len_reload", 32'(n), 32'd16);
        lookup_lit("after_rl1", 4'd1, 10'd0, 10'd11, 1'b0);
        lookup_lit("after_rl4", 4'd4, 10'd0, 10'd55, 1'b0);
        lookup_lit("after_rl5", 4'd5, 10'd0, 10'd109, 1'b0);
        lookup_lit("after_rl12", 4'd12, 10'd4, 10'd0, 1'b1);

        // Reset at INIT cycle 5.
        do_cycle(1'b0, 4'd0, 10'd0, 1'b0, 4'd0, 10'd0, 1'b0, 1'b1);
        repeat (5) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midinit_rst_ready",  32'(lk_ready),  32'd0);
        chk("midinit_rst_valid",  32'(lk_valid),  32'd0);
        chk("midinit_rst_target", 32'(lk_target), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        count_init(n);
        chk("init_len_after_rst", 32'(n), 32'd16);

        // Reset landing between lookup request and its result edge.
        lk_req  = 1'b1;
        lk_addr = 4'd2;
        #2;
        rst_n = 1'b0;
        model_reset();
        clear_inputs();
        tick();
        rst_n = 1'b1;
        count_init(n);
        chk("init_len_midlookup", 32'(n), 32'd16);
        chk("no_stale_pulse", 32'(lk_valid), 32'd0);

        // Mixed writes and lookups checked by the model.
        for (int i = 0; i < 8; i++) begin
            do_cycle(1'b0, 4'd0, 10'd0, 1'b1, 4'(2 * i), 10'($urandom_range(0, 1023)),
                     1'(i % 2), 1'b0);
        end
        for (int a = 0; a < 16; a++) begin
            do_cycle(1'b1, 4'(a), 10'($urandom_range(0, 1023)), 1'(a % 3 == 0),
                     4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)), 1'(a % 2), 1'b0);
        end
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
